// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX stage for RV32I. Decodes an instruction into ALU
// opcode, operands and writeback/branch control. A main output register plus
// one skid register keep full throughput behind a registered in_ready.
module alu_issue_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_aluctr,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_is_branch,
    output logic [2:0]      out_funct3,
    output logic            out_illegal
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [3:0]      aluctr;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            rd_we;
        logic            is_branch;
        logic [2:0]      funct3;
        logic            illegal;
    } op_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            alt;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [3:0]      f3_op;
    logic [3:0]      f3_opimm;
    op_t             dec;

    // rs1/rs2 index fields are consumed upstream by the register file
    logic            unused_rs_idx;

    op_t  main_q, main_d;
    op_t  skid_q, skid_d;
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic accept;
    logic consume;

    assign opcode        = in_instr[6:0];
    assign funct3        = in_instr[14:12];
    assign alt           = in_instr[30];
    assign imm_i         = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s         = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u         = {in_instr[31:12], 12'b0};
    assign unused_rs_idx = ^in_instr[19:15];

    // funct3 -> ALU opcode for OP; OP-IMM differs only in ignoring alt for 000
    always_comb begin
        f3_op = ALU_ADD;
        case (funct3)
            3'b000:  f3_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b011:  f3_op = ALU_SLTU;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
        f3_opimm = (funct3 == 3'b000) ? ALU_ADD : f3_op;
    end

    // Combinational decode of the presented instruction
    always_comb begin
        dec        = '0;
        dec.aluctr = ALU_ADD;
        dec.rd     = in_instr[11:7];
        dec.funct3 = funct3;
        case (opcode)
            OPC_OP: begin
                dec.a      = in_rs1;
                dec.b      = in_rs2;
                dec.aluctr = f3_op;
                dec.rd_we  = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.a      = in_rs1;
                dec.b      = imm_i;
                dec.aluctr = f3_opimm;
                dec.rd_we  = 1'b1;
            end
            OPC_LUI: begin
                dec.b     = imm_u;
                dec.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a     = in_pc;
                dec.b     = imm_u;
                dec.rd_we = 1'b1;
            end
            OPC_LOAD: begin
                dec.a     = in_rs1;
                dec.b     = imm_i;
                dec.rd_we = 1'b1;
            end
            OPC_STORE: begin
                dec.a = in_rs1;
                dec.b = imm_s;
            end
            OPC_BRANCH: begin
                dec.a         = in_rs1;
                dec.b         = in_rs2;
                dec.is_branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: dec.aluctr = ALU_SUB;
                    3'b100, 3'b101: dec.aluctr = ALU_SLT;
                    3'b110, 3'b111: dec.aluctr = ALU_SLTU;
                    default: begin
                        // Undefined branch condition: treat like an unknown opcode
                        dec.a         = '0;
                        dec.b         = '0;
                        dec.is_branch = 1'b0;
                        dec.illegal   = 1'b1;
                    end
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                dec.a     = in_pc;
                dec.b     = XLEN'(4);
                dec.rd_we = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (dec.rd == 5'd0) begin
            dec.rd_we = 1'b0;
        end
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready & ~flush;
    assign consume  = main_valid_q & out_ready;

    // Next state of main/skid entries; flush overrides everything
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                // accept is impossible here since in_ready is low
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid     = main_valid_q;
    assign out_aluctr    = main_q.aluctr;
    assign out_a         = main_q.a;
    assign out_b         = main_q.b;
    assign out_rd        = main_q.rd;
    assign out_rd_we     = main_q.rd_we;
    assign out_is_branch = main_q.is_branch;
    assign out_funct3    = main_q.funct3;
    assign out_illegal   = main_q.illegal;

endmodule
